yadmc_tdpram: RTL and testbench



---
 rtl/yadmc_pkg.sv | 17 +
 rtl/yadmc_tdpram_port.sv | 81 ++++++++
 rtl/yadmc_tdpram.sv | 136 +++++++++++++
 tb/tb_yadmc_tdpram.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/yadmc_pkg.sv
// Shared YADMC definitions: write-mode constants, clear-FSM state encoding and
// the byte-lane count helper used to size write-enable ports.
package yadmc_pkg;

  localparam int YADMC_READ_FIRST  = 0;
  localparam int YADMC_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } yadmc_state_e;

  function automatic int yadmc_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/yadmc_tdpram_port.sv
// One RAM port: byte-lane merge against the stored word, read-first/write-first
// select and the registered read stage (plus a second stage under YADMC_TDPRAM_OUTREG_EN).
module yadmc_tdpram_port
  import yadmc_pkg::*;
#(
  parameter int  data_width  = 32,
  parameter int  byte_width  = 8,
  parameter int  write_first = YADMC_READ_FIRST,
  parameter bit  primary     = 1'b1,
  localparam int NB          = yadmc_lanes(data_width, byte_width)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  clearing,
  input  logic                  acc,
  input  logic [NB-1:0]         we,
  input  logic [data_width-1:0] di,
  input  logic [NB-1:0]         oth_we,
  input  logic [data_width-1:0] oth_di,
  input  logic [data_width-1:0] old_word,
  output logic [data_width-1:0] new_word,
  output logic [data_width-1:0] do_o
);

  logic [data_width-1:0] rd_word;
  logic [data_width-1:0] rdat_q, rdat_d;

  // oth_we is only non-zero on a same-address collision; port 0 owns contested lanes.
  always_comb begin
    new_word = old_word;
    for (int k = 0; k < NB; k++) begin
      if (primary) begin
        if (we[k])          new_word[k*byte_width +: byte_width] = di[k*byte_width +: byte_width];
        else if (oth_we[k]) new_word[k*byte_width +: byte_width] = oth_di[k*byte_width +: byte_width];
      end else begin
        if (oth_we[k])      new_word[k*byte_width +: byte_width] = oth_di[k*byte_width +: byte_width];
        else if (we[k])     new_word[k*byte_width +: byte_width] = di[k*byte_width +: byte_width];
      end
    end
  end

  assign rd_word = (write_first == YADMC_WRITE_FIRST) ? new_word : old_word;

  always_comb begin
    rdat_d = rdat_q;
    if (clearing) rdat_d = '0;
    else if (acc) rdat_d = rd_word;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rdat_q <= '0;
    else         rdat_q <= rdat_d;
  end

`ifdef YADMC_TDPRAM_OUTREG_EN
  logic                  acc_q, acc_d;
  logic [data_width-1:0] dout_q, dout_d;

  always_comb begin
    acc_d  = acc;
    dout_d = dout_q;
    if (clearing)   dout_d = '0;
    else if (acc_q) dout_d = rdat_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign do_o = dout_q;
`else
  assign do_o = rdat_q;
`endif

endmodule

// File: rtl/yadmc_tdpram.sv
// True dual-port RAM with byte enables, collision merge/flag and a post-reset
// zero-fill sequencer. Define YADMC_TDPRAM_OUTREG_EN for a 2-cycle output path.
module yadmc_tdpram
  import yadmc_pkg::*;
#(
  parameter int  address_depth = 10,
  parameter int  data_width    = 32,
  parameter int  byte_width    = 8,
  parameter int  write_first   = YADMC_READ_FIRST,
  localparam int NB            = yadmc_lanes(data_width, byte_width)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  output logic                     init_busy,
  input  logic [address_depth-1:0] adr0,
  input  logic                     en0,
  input  logic [NB-1:0]            we0,
  input  logic [data_width-1:0]    di0,
  output logic [data_width-1:0]    do0,
  input  logic [address_depth-1:0] adr1,
  input  logic                     en1,
  input  logic [NB-1:0]            we1,
  input  logic [data_width-1:0]    di1,
  output logic [data_width-1:0]    do1,
  output logic                     collision
);

  localparam int DEPTH = 1 << address_depth;

  logic [data_width-1:0]    mem [DEPTH];
  yadmc_state_e             state_q, state_d;
  logic [address_depth-1:0] cnt_q, cnt_d;
  logic                     init_busy_q, init_busy_d;
  logic                     coll_q, coll_d;
  logic                     clearing, acc0, acc1, coll_now;
  logic [NB-1:0]            we0_a, we1_a, oth0_we, oth1_we;
  logic [data_width-1:0]    old0, old1, new0, new1;

  assign clearing = (state_q == CLEAR);
  assign acc0     = en0 & ~clearing & ~sys_rst;
  assign acc1     = en1 & ~clearing & ~sys_rst;
  assign we0_a    = acc0 ? we0 : '0;
  assign we1_a    = acc1 ? we1 : '0;
  assign coll_now = acc0 & acc1 & (adr0 == adr1) & (|{we0_a, we1_a});
  assign oth0_we  = coll_now ? we1_a : '0;
  assign oth1_we  = coll_now ? we0_a : '0;
  assign old0     = mem[adr0];
  assign old1     = mem[adr1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = READY;
    end
    init_busy_d = (state_d == CLEAR);
    coll_d      = coll_now;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      coll_q      <= coll_d;
    end
  end

  // On a collision both ports carry the same merged word, so write order is moot.
  always_ff @(posedge sys_clk) begin
    if (clearing) begin
      mem[cnt_q] <= '0;
    end else begin
      if (|we1_a) mem[adr1] <= new1;
      if (|we0_a) mem[adr0] <= new0;
    end
  end

  yadmc_tdpram_port #(
    .data_width (data_width),
    .byte_width (byte_width),
    .write_first(write_first),
    .primary    (1'b1)
  ) u_port0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clearing(clearing),
    .acc     (acc0),
    .we      (we0_a),
    .di      (di0),
    .oth_we  (oth0_we),
    .oth_di  (di1),
    .old_word(old0),
    .new_word(new0),
    .do_o    (do0)
  );

  yadmc_tdpram_port #(
    .data_width (data_width),
    .byte_width (byte_width),
    .write_first(write_first),
    .primary    (1'b0)
  ) u_port1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clearing(clearing),
    .acc     (acc1),
    .we      (we1_a),
    .di      (di1),
    .oth_we  (oth1_we),
    .oth_di  (di0),
    .old_word(old1),
    .new_word(new1),
    .do_o    (do1)
  );

  assign init_busy = init_busy_q;

`ifdef YADMC_TDPRAM_OUTREG_EN
  logic coll2_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) coll2_q <= 1'b0;
    else         coll2_q <= coll_q;
  end
  assign collision = coll2_q;
`else
  assign collision = coll_q;
`endif

endmodule

// File: tb/tb_yadmc_tdpram.sv
// Bench for yadmc_tdpram: read-first and write-first instances share stimulus and
// are checked every cycle against a word-level model, plus literal scenario checks.
module tb_yadmc_tdpram;

`ifdef YADMC_TDPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en0, en1;
  logic [AW-1:0] adr0, adr1;
  logic [3:0]    we0, we1;
  logic [31:0]   di0, di1;

  logic        busy_rf, busy_wf, col_rf, col_wf;
  logic [31:0] do0_rf, do1_rf, do0_wf, do1_wf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  yadmc_tdpram #(.address_depth(AW), .data_width(32), .byte_width(8), .write_first(0)) dut_rf (
    .sys_clk(clk), .sys_rst(rst), .init_busy(busy_rf),
    .adr0(adr0), .en0(en0), .we0(we0), .di0(di0), .do0(do0_rf),
    .adr1(adr1), .en1(en1), .we1(we1), .di1(di1), .do1(do1_rf),
    .collision(col_rf));

  yadmc_tdpram #(.address_depth(AW), .data_width(32), .byte_width(8), .write_first(1)) dut_wf (
    .sys_clk(clk), .sys_rst(rst), .init_busy(busy_wf),
    .adr0(adr0), .en0(en0), .we0(we0), .di0(di0), .do0(do0_wf),
    .adr1(adr1), .en1(en1), .we1(we1), .di1(di1), .do1(do1_wf),
    .collision(col_wf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [DEPTH];
  logic [31:0] s1_do [2][2];   // [write_first][port]
  logic [31:0] s2_do [2][2];
  logic [31:0] e_do  [2][2];
  logic        s1_col, s2_col, e_col, busy_m;
  int          clr_left;
  bit          m_live = 0;

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = base;
    for (int k = 0; k < 4; k++) if (we[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  initial begin
    logic [31:0] o0, o1, n0, n1;
    logic        col;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_live   = 1;
        busy_m   = 1;
        clr_left = DEPTH;
        for (int w = 0; w < 2; w++) for (int p = 0; p < 2; p++) begin
          s1_do[w][p] = 0; s2_do[w][p] = 0;
        end
        s1_col = 0; s2_col = 0;
      end else if (m_live) begin
        s2_do  = s1_do;
        s2_col = s1_col;
        if (busy_m) begin
          mem_m[DEPTH - clr_left] = 0;
          clr_left--;
          busy_m = (clr_left != 0);
          for (int w = 0; w < 2; w++) for (int p = 0; p < 2; p++) s1_do[w][p] = 0;
          s1_col = 0;
        end else begin
          o0  = mem_m[adr0];
          o1  = mem_m[adr1];
          col = en0 && en1 && (adr0 == adr1) && ((we0 != 0) || (we1 != 0));
          if (col) begin
            n0 = merge(merge(o0, we1, di1), we0, di0);
            n1 = n0;
          end else begin
            n0 = merge(o0, we0, di0);
            n1 = merge(o1, we1, di1);
          end
          if (en1) mem_m[adr1] = n1;
          if (en0) mem_m[adr0] = n0;
          if (en0) begin s1_do[0][0] = o0; s1_do[1][0] = n0; end
          if (en1) begin s1_do[0][1] = o1; s1_do[1][1] = n1; end
          s1_col = col;
        end
      end
      if (LAT == 2) begin e_do = s2_do; e_col = s2_col; end
      else          begin e_do = s1_do; e_col = s1_col; end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy_rf", {31'd0, busy_rf}, {31'd0, busy_m});
      chk("busy_wf", {31'd0, busy_wf}, {31'd0, busy_m});
      chk("do0_rf",  do0_rf, e_do[0][0]);
      chk("do1_rf",  do1_rf, e_do[0][1]);
      chk("do0_wf",  do0_wf, e_do[1][0]);
      chk("do1_wf",  do1_wf, e_do[1][1]);
      chk("col_rf",  {31'd0, col_rf}, {31'd0, e_col});
      chk("col_wf",  {31'd0, col_wf}, {31'd0, e_col});
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic e0, input logic [AW-1:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                    input logic e1, input logic [AW-1:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    en0 = e0; adr0 = a0; we0 = w0; di0 = d0;
    en1 = e1; adr1 = a1; we1 = w1; di1 = d1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy_rf && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst = 1;
    en0 = 0; en1 = 0; adr0 = 0; adr1 = 0; we0 = 0; we1 = 0; di0 = 0; di1 = 0;
    @(negedge clk);
    idle(2);
    rst = 0;
    wait_busy(n);
    chk("init_clear_len", n, 16);

    // fill, then reset must zero everything
    for (int a = 0; a < DEPTH; a++) op(1, a[AW-1:0], 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    rst = 1; idle(1); rst = 0;
    wait_busy(n);
    chk("reclear_len", n, 16);
    for (int a = 0; a < DEPTH; a++) op(1, a[AW-1:0], 4'h0, 0, 1, a[AW-1:0], 4'h0, 0);
    idle(LAT - 1);
    chk("clear_zero_p0", do0_rf, 32'h0);
    chk("clear_zero_p1", do1_wf, 32'h0);

    // byte lanes
    op(1, 5, 4'hF, 32'h1122_3344, 0, 0, 0, 0);
    op(1, 5, 4'h5, 32'hAABB_CCDD, 0, 0, 0, 0);
    op(1, 5, 4'h0, 0, 0, 0, 0, 0);
    idle(LAT - 1);
    chk("lane_merge_rf", do0_rf, 32'h11BB_33DD);
    chk("lane_merge_wf", do0_wf, 32'h11BB_33DD);
    idle(3);
    chk("en0_hold", do0_rf, 32'h11BB_33DD);

    // read-during-write
    op(0, 0, 0, 0, 1, 3, 4'hF, 32'h1);
    op(0, 0, 0, 0, 1, 3, 4'hF, 32'h2);
    idle(LAT - 1);
    chk("rdw_read_first", do1_rf, 32'h1);
    chk("rdw_write_first", do1_wf, 32'h2);
    op(0, 0, 0, 0, 1, 3, 4'h0, 0);
    idle(LAT - 1);
    chk("rdw_after_rf", do1_rf, 32'h2);
    chk("rdw_after_wf", do1_wf, 32'h2);

    // collision
    op(1, 7, 4'hF, 32'h0, 0, 0, 0, 0);
    op(1, 7, 4'b0011, 32'h0000_AAAA, 1, 7, 4'hF, 32'h5555_5555);
    idle(LAT - 1);
    chk("coll_flag", {31'd0, col_rf}, 32'd1);
    chk("coll_rf_old", do0_rf, 32'h0);
    chk("coll_wf_merged", do1_wf, 32'h5555_AAAA);
    idle(1);
    chk("coll_pulse_end", {31'd0, col_wf}, 32'd0);
    op(1, 7, 4'h0, 0, 0, 0, 0, 0);
    idle(LAT - 1);
    chk("coll_word", do0_rf, 32'h5555_AAAA);
    op(1, 7, 4'h3, 32'h1234_5678, 1, 8, 4'hF, 32'h9ABC_DEF0);
    idle(LAT - 1);
    chk("no_coll_diff_adr", {31'd0, col_wf}, 32'd0);

    // reset at clear count 9, writes attempted throughout clear
    rst = 1; idle(1); rst = 0;
    idle(9);
    rst = 1;
    op(1, 2, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    rst = 0;
    en0 = 1; adr0 = 0; we0 = 4'hF; di0 = 32'hCAFE_F00D;
    en1 = 1; adr1 = 1; we1 = 4'hF; di1 = 32'hBEEF_0001;
    wait_busy(n);
    chk("midclear_len", n, 16);
    en0 = 0; en1 = 0; we0 = 0; we1 = 0;
    op(1, 0, 4'h0, 0, 1, 1, 4'h0, 0);
    idle(LAT - 1);
    chk("clear_no_trace0", do0_rf, 32'h0);
    chk("clear_no_trace1", do1_wf, 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] ra0, ra1;
      rst = ($urandom_range(0, 399) == 0);
      ra0 = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra1 = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      op($urandom_range(0, 9) < 7, ra0, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom,
         $urandom_range(0, 9) < 7, ra1, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom);
    end
    rst = 0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
